// File: rtl/param_processor_if.sv
// param_processor_if: start/instruction, status and debug-read signals of param_processor
interface param_processor_if #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
);
  localparam int RW = $clog2(NREGS);
  logic              run;
  logic [DATA_W-1:0] din;
  logic [RW-1:0]     rd_sel;
  logic [DATA_W-1:0] rd_data;
  logic              done;
  logic              busy;
  logic              z_flag;
  logic              c_flag;
  modport master (output run, din, rd_sel, input rd_data, done, busy, z_flag, c_flag);
  modport slave  (input run, din, rd_sel, output rd_data, done, busy, z_flag, c_flag);
endinterface

// File: rtl/param_processor.sv
// param_processor: multi-cycle register-file processor (mv/mvi/add/sub/and/or/xor) with z/c flags
module param_processor #(
  parameter int DATA_W = 16,
  parameter int NREGS  = 8
) (
  input  logic           clk_50MHz,
  input  logic           reset,
  param_processor_if.slave bus
);
  localparam int RW = $clog2(NREGS);
  localparam logic [DATA_W:0] ONE = 1;
  if (DATA_W < 3 + 2 * RW || NREGS < 2 || NREGS > 16 || (NREGS & (NREGS - 1)) != 0) begin : g_bad_param
    $error("param_processor: unsupported DATA_W/NREGS combination");
  end
  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;
  state_t            state_q;
  logic [DATA_W-1:0] r_q [NREGS];
  logic [2:0]        op_q;
  logic [RW-1:0]     rx_q, ry_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W:0]   g_q, g_d;
  logic              done_q, busy_q, z_q, c_q;
  logic [2:0]        op_in;
  logic [DATA_W-1:0] ry_v;
  logic              alu_in, alu_q;
  assign op_in  = bus.din[2*RW+2:2*RW];
  assign alu_in = op_in inside {[3'd2:3'd6]};
  assign alu_q  = op_q inside {[3'd2:3'd6]};
  assign ry_v   = r_q[ry_q];
  always_comb
    g_d = op_q == 3'd2 ? {1'b0, a_q} + {1'b0, ry_v} :
          op_q == 3'd3 ? {1'b0, a_q} + {1'b0, ~ry_v} + ONE :
          op_q == 3'd4 ? {1'b0, a_q & ry_v} :
          op_q == 3'd5 ? {1'b0, a_q | ry_v} :
          op_q == 3'd6 ? {1'b0, a_q ^ ry_v} : '0;
  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) r_q[i] <= '0;
      state_q <= IDLE;
      op_q    <= '0;
      rx_q    <= '0;
      ry_q    <= '0;
      a_q     <= '0;
      g_q     <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      z_q     <= 1'b0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (bus.run) begin
          op_q    <= op_in;
          rx_q    <= bus.din[2*RW-1:RW];
          ry_q    <= bus.din[RW-1:0];
          state_q <= DECODE;
          busy_q  <= 1'b1;
          done_q  <= !alu_in;
        end
        DECODE: begin
          if (op_q == 3'd0) r_q[rx_q] <= r_q[ry_q];
          if (op_q == 3'd1) r_q[rx_q] <= bus.din;
          if (alu_q) a_q <= r_q[rx_q];
          state_q <= alu_q ? EXEC : IDLE;
          busy_q  <= alu_q;
          done_q  <= 1'b0;
        end
        EXEC: begin
          g_q     <= g_d;
          state_q <= WB;
          done_q  <= 1'b1;
        end
        default: begin
          r_q[rx_q] <= g_q[DATA_W-1:0];
          z_q       <= g_q[DATA_W-1:0] == '0;
          c_q       <= g_q[DATA_W];
          state_q   <= IDLE;
          busy_q    <= 1'b0;
          done_q    <= 1'b0;
        end
      endcase
    end
  end
  assign bus.rd_data = r_q[bus.rd_sel];
  assign bus.done    = done_q;
  assign bus.busy    = busy_q;
  assign bus.z_flag  = z_q;
  assign bus.c_flag  = c_q;
endmodule

// File: tb/tb_param_processor.sv
// tb_param_processor: randomized scoreboard bench for param_processor against an instruction-level model
module tb_param_processor;
  typedef struct packed {
    logic [31:0]      cyc;
    logic [7:0][15:0] r;
    logic             z;
    logic             c;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] cyc = 0;
  logic        use_stim;
  logic [2:0]  sel_stim, sel_mon;
  int          checks = 0;
  int          errors = 0;
  logic [15:0] m [8];
  logic        mz, mc;
  exp_t        q [$];
  param_processor_if #(.DATA_W(16), .NREGS(8)) bus ();
  param_processor #(.DATA_W(16), .NREGS(8)) dut (.clk_50MHz(clk), .reset(reset), .bus(bus));
  assign bus.rd_sel = use_stim ? sel_stim : sel_mon;
  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask
  function automatic exp_t model_step(input logic [15:0] ins, input logic [15:0] imm, input logic [31:0] s);
    exp_t e;
    logic [2:0]  op = ins[8:6];
    logic [2:0]  rx = ins[5:3];
    logic [2:0]  ry = ins[2:0];
    logic [31:0] a = {16'h0, m[rx]};
    logic [31:0] b = {16'h0, m[ry]};
    logic [31:0] res;
    if (op == 3'd0) m[rx] = m[ry];
    else if (op == 3'd1) m[rx] = imm;
    else if (op != 3'd7) begin
      case (op)
        3'd2:    res = a + b;
        3'd3:    res = a + (b ^ 32'hFFFF) + 1;
        3'd4:    res = a & b;
        3'd5:    res = a | b;
        default: res = a ^ b;
      endcase
      m[rx] = res[15:0];
      mz = res[15:0] == 16'h0;
      mc = res[16];
    end
    e.cyc = s + ((op >= 3'd2 && op <= 3'd6) ? 32'd2 : 32'd0);
    for (int i = 0; i < 8; i++) e.r[i] = m[i];
    e.z = mz;
    e.c = mc;
    return e;
  endfunction
  task automatic run_one(input logic [15:0] ins, input logic [15:0] imm);
    int n = 0;
    bus.din = ins;
    bus.run = 1'b1;
    while (bus.busy && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) begin
      chk("idle_timeout", 32'd1, 32'd0);
      return;
    end
    @(posedge clk);
    #1;
    q.push_back(model_step(ins, imm, cyc));
    @(negedge clk);
    bus.din = imm;
    if (ins[8:6] == 3'd1) @(negedge clk);
  endtask
  task automatic check_cleared(input string nm);
    chk({nm, "_busy"}, {31'h0, bus.busy}, 32'd0);
    chk({nm, "_done"}, {31'h0, bus.done}, 32'd0);
    chk({nm, "_z"}, {31'h0, bus.z_flag}, 32'd0);
    chk({nm, "_c"}, {31'h0, bus.c_flag}, 32'd0);
    use_stim = 1'b1;
    for (int i = 0; i < 8; i++) begin
      sel_stim = 3'(i);
      #1;
      chk($sformatf("%s_R%0d", nm, i), {16'h0, bus.rd_data}, 32'd0);
    end
    use_stim = 1'b0;
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
    mz = 1'b0;
    mc = 1'b0;
  endtask
  function automatic logic [15:0] pick_imm();
    case ($urandom_range(0, 3))
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction
  initial begin
    sel_mon = 3'd0;
    forever begin
      exp_t e;
      @(negedge clk);
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 32'd1, 32'd0);
        else begin
          e = q.pop_front();
          chk("done_cycle", cyc, e.cyc);
          @(posedge clk);
          #1;
          for (int i = 0; i < 8; i++) begin
            sel_mon = 3'(i);
            #1;
            chk($sformatf("R%0d", i), {16'h0, bus.rd_data}, {16'h0, e.r[i]});
          end
          chk("z_flag", {31'h0, bus.z_flag}, {31'h0, e.z});
          chk("c_flag", {31'h0, bus.c_flag}, {31'h0, e.c});
        end
      end
    end
  end
  initial begin
    reset = 1'b1;
    bus.run = 1'b0;
    bus.din = 16'h0;
    use_stim = 1'b0;
    sel_stim = 3'd0;
    for (int i = 0; i < 8; i++) m[i] = 16'h0;
    mz = 1'b0;
    mc = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check_cleared("reset");
    @(negedge clk);
    run_one(16'h0040, 16'h0005);
    run_one(16'h0048, 16'hFFFF);
    bus.run = 1'b0;
    @(negedge clk);
    run_one(16'h0081, 16'($urandom));
    bus.run = 1'b0;
    @(negedge clk);
    run_one(16'h00C9, 16'($urandom));
    run_one(16'h0010, 16'($urandom));
    bus.run = 1'b0;
    @(negedge clk);
    run_one(16'h01C0, 16'($urandom));
    bus.run = 1'b0;
    @(negedge clk);
    run_one(16'h0081, 16'($urandom));
    run_one(16'h0081, 16'($urandom));
    bus.run = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 8; i++) run_one({10'h001, 3'(i), 3'd0}, 16'($urandom) | 16'h1);
    run_one(16'h00D2, 16'($urandom));
    run_one(16'h0050, 16'h1234);
    bus.run = 1'b0;
    repeat (3) @(negedge clk);
    bus.din = 16'h0081;
    bus.run = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_cleared("abort");
    @(negedge clk);
    repeat (150) begin
      run_one({7'($urandom), 3'($urandom), 3'($urandom), 3'($urandom)}, pick_imm());
      if ($urandom_range(0, 2) == 0) begin
        bus.run = 1'b0;
        repeat ($urandom_range(1, 3)) @(negedge clk);
      end
    end
    bus.run = 1'b0;
    repeat (10) @(negedge clk);
    chk("queue_drained", q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/param_processor.md
PARAM_PROCESSOR -- requirements
Module: param_processor

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath and register width in bits.
REQ-002 SHALL have parameter NREGS, default 8, number of general-purpose registers; power of two, 2..16; RW = clog2(NREGS).
REQ-003 SHALL have port clk_50MHz  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port run  input  1  start request, sampled only in IDLE.
REQ-006 SHALL have port din  input  DATA_W  instruction word, or immediate operand for mvi.
REQ-007 SHALL have port rd_sel  input  RW  debug register select.
REQ-008 SHALL have port rd_data  output  DATA_W  combinational value of R[rd_sel].
REQ-009 SHALL have port done  output  1  high during the final cycle of every instruction.
REQ-010 SHALL have port busy  output  1  high whenever the state is not IDLE.
REQ-011 SHALL have port z_flag  output  1  zero flag of the last ALU result.
REQ-012 SHALL have port c_flag  output  1  carry flag of the last ALU result.

Function
REQ-013 SHALL elaborate only when DATA_W >= 3 + 2*RW; the instruction uses din[2RW+2:2RW] = opcode, din[2RW-1:RW] = RX, din[RW-1:0] = RY, and upper bits are ignored.
REQ-014 SHALL decode opcodes: 000 mv RX<-RY; 001 mvi RX<-din; 010 add; 011 sub; 100 and; 101 or; 110 xor; 111 reserved (no operation).
REQ-015 SHALL implement states IDLE, DECODE, EXEC, WB.
REQ-016 IDLE: if run=1, IR <= instruction fields and state -> DECODE; otherwise hold.
REQ-017 DECODE, mv: RX <= RY, done=1, -> IDLE.
REQ-018 DECODE, mvi: RX <= din sampled this cycle, done=1, -> IDLE.
REQ-019 DECODE, reserved: no register or flag write, done=1, -> IDLE.
REQ-020 DECODE, ALU op: A <= RX, -> EXEC.
REQ-021 EXEC: G <= A op RY, -> WB.
REQ-022 WB: RX <= G, z_flag <= (G==0), c_flag updated, done=1, -> IDLE.
REQ-023 Latency from the IDLE edge sampling run=1: done high 1 cycle later for mv/mvi/reserved and 3 cycles later for ALU ops; each done pulse is exactly one cycle.
REQ-024 add SHALL compute A+RY modulo 2^DATA_W; c = carry out of bit DATA_W-1.
REQ-025 sub SHALL compute A + ~RY + 1 modulo 2^DATA_W; c = carry out (1 = no borrow).
REQ-026 and/or/xor SHALL clear c_flag.
REQ-027 z_flag/c_flag SHALL change only in WB.
REQ-028 RX == RY SHALL be legal; the operand is read before the write (add R1,R1 doubles R1).
REQ-029 run SHALL be ignored while busy=1; a run held high SHALL start a new instruction on the first IDLE cycle after done.
REQ-030 rd_data SHALL reflect register writes from the cycle after the write edge.

Reset
REQ-031 reset=1 at a clock edge SHALL clear R0..R(NREGS-1), IR, A, and G to 0, clear z_flag and c_flag to 0, and set the state to IDLE, with done=0 and busy=0 from the next cycle.
REQ-032 reset SHALL take priority over all other activity in any state, including mid-instruction; the aborted instruction SHALL make no register write.

Verification (DATA_W=16, NREGS=8)
REQ-033 din=0x040, then 0x0005; then 0x048, then 0xFFFF -> R0=0x0005, R1=0xFFFF; done high 1 cycle after each run sample.
REQ-034 din=0x081 (add R0,R1) -> done 3 cycles after the run sample; R0=0x0004, c_flag=1, z_flag=0.
REQ-035 din=0x0C9 (sub R1,R1) -> R1=0x0000, z_flag=1, c_flag=1; then din=0x010 (mv R2,R0) -> R2=0x0004, flags unchanged.
REQ-036 din=0x1C0 (reserved) -> done 1 cycle after the run sample; all registers and flags unchanged.
REQ-037 Hold run=1 for two back-to-back add instructions -> two done pulses 4 cycles apart; run is ignored while busy=1.
REQ-038 Assert reset during EXEC of an add -> next cycle: all registers 0, flags 0, busy=0, done=0, and no write to RX.
